// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage: fetches one instruction per req/ack handshake and advances the PC when the downstream stage is done.
// Optional PC_ALIGN_CHECK_EN: a misaligned next PC traps into HALT instead of being silently realigned.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  next_op,
  input  logic [31:0] jr_target,
  input  logic        exec_done,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        align_err
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif

  state_t      state, state_nxt;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        ld_instr, ld_pc;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign op        = instr[31:26];
  assign func      = instr[5:0];
  assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (next_op)
      2'b00:   next_pc = pc_plus4;
      2'b01:   next_pc = pc_plus4 + br_off;
      2'b10:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: next_pc = jr_target;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    align_err   = 1'b0;
    ld_instr    = 1'b0;
    ld_pc       = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ld_instr  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (exec_done) begin
`ifdef PC_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            state_nxt = HALT;
          end else begin
            ld_pc     = 1'b1;
            state_nxt = FETCH;
          end
`else
          ld_pc     = 1'b1;
          state_nxt = FETCH;
`endif
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      HALT: align_err = 1'b1;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Low PC bits are cleared on load; with the trap enabled they are already zero here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (ld_pc)    pc    <= next_pc & ~32'h3;
      if (ld_instr) instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: a memory/controller driver plus an arithmetic next-PC reference model.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  next_op;
  logic [31:0] jr_target;
  logic        exec_done;
  logic [31:0] instr;
  logic [5:0]  op, func;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        align_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  logic        halted;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .next_op(next_op),
    .jr_target(jr_target), .exec_done(exec_done), .instr(instr), .op(op),
    .func(func), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next-PC from the ISA rules, in plain integer arithmetic.
  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic [31:0] w,
                                             input logic [1:0] sel, input logic [31:0] jt);
    int          off;
    logic [31:0] offu, seq;
    seq  = cur + 32'd4;
    off  = $signed(w[15:0]);
    offu = off * 4;
    case (sel)
      2'd0:    return seq;
      2'd1:    return seq + offu;
      2'd2:    return (seq & 32'hF000_0000) | (w[25:0] * 32'd4);
      default: return jt;
    endcase
  endfunction

  task automatic wait_req();
    int t = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) chk("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic do_instr(input logic [31:0] word, input logic [1:0] sel, input logic [31:0] jt,
                          input int ack_dly, input int done_dly);
    logic [31:0] tgt;
    wait_req();
    chk("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < ack_dly; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("req_hold", {31'b0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, exp_pc);
    end
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("exec_valid", {31'b0, instr_valid}, 32'd1);
    chk("exec_req", {31'b0, imem_req}, 32'd0);
    chk("instr", instr, word);
    chk("op", {26'b0, op}, {26'b0, word[31:26]});
    chk("func", {26'b0, func}, {26'b0, word[5:0]});
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    for (int i = 0; i < done_dly; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      next_op    = 2'($urandom);
      @(negedge clk);
      chk("stall_instr", instr, word);
      chk("stall_pc", pc, exp_pc);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    imem_ack  = 1'b0;
    exec_done = 1'b1;
    next_op   = sel;
    jr_target = jt;
    @(negedge clk);
    exec_done = 1'b0;
    tgt = ref_target(exp_pc, word, sel, jt);
`ifdef PC_ALIGN_CHECK_EN
    if (tgt[1:0] != 2'b00) halted = 1'b1;
    else exp_pc = tgt;
`else
    exp_pc = {tgt[31:2], 2'b00};
`endif
  endtask

  initial begin
    logic [31:0] w, jt;
    logic [1:0]  s;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; next_op = '0;
    jr_target = '0; exec_done = 1'b0; halted = 1'b0; exp_pc = 32'h0;
    #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_align", {31'b0, align_err}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_req_clk", {31'b0, imem_req}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed walk: sequential, backward branch, jal, jr, and wrap at the top of memory.
    do_instr(32'h1111_0001, 2'd0, 32'h0, 2, 0);
    do_instr(32'h2222_0002, 2'd0, 32'h0, 2, 5);
    do_instr(32'h3333_0003, 2'd3, 32'h0000_0100, 0, 0);
    do_instr(32'h1000_FFFE, 2'd1, 32'h0, 1, 1);
    chk("branch_back", exp_pc, 32'h0000_00FC);
    do_instr(32'h0000_0008, 2'd3, 32'h4000_0010, 0, 0);
    do_instr(32'h0C00_0040, 2'd2, 32'h0, 0, 0);
    chk("jal_target", exp_pc, 32'h4000_0100);
    do_instr(32'h0000_0008, 2'd3, 32'h4000_0014, 3, 2);
    do_instr(32'h0000_0008, 2'd3, 32'hFFFF_FFFC, 0, 0);
    do_instr(32'hAAAA_5555, 2'd0, 32'h0, 1, 0);
    chk("wrap", exp_pc, 32'h0);

    for (int k = 0; k < 40; k++) begin
      w  = $urandom;
      s  = 2'($urandom);
      jt = $urandom;
`ifdef PC_ALIGN_CHECK_EN
      jt[1:0] = 2'b00;
`endif
      do_instr(w, s, jt, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a fetch is outstanding; an ack arriving in IDLE must be ignored.
    wait_req();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, imem_req}, 32'd0);
    chk("rst_mid_pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    chk("late_ack_instr", instr, 32'h0);
    exp_pc = 32'h0;
    do_instr(32'h0000_0008, 2'd3, 32'h0000_0200, 0, 0);

    do_instr(32'h0000_0008, 2'd3, 32'h0000_0102, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    chk("halted_flag", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1; exec_done = 1'b1;
      @(negedge clk);
      chk("halt_err", {31'b0, align_err}, 32'd1);
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_valid", {31'b0, instr_valid}, 32'd0);
      chk("halt_pc", pc, 32'h0000_0200);
    end
    imem_ack = 1'b0; exec_done = 1'b0;
`else
    chk("realign", exp_pc, 32'h0000_0100);
    do_instr(32'h0000_0001, 2'd0, 32'h0, 1, 0);
    chk("align_err_tied", {31'b0, align_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
